// File: rtl/vgaram_pkg.sv
// Shared defaults and FSM state encoding for the VGA RAM write arbiter.
package vgaram_pkg;

  localparam int VGARAM_WIDTH     = 16;
  localparam int VGARAM_ADDR_BITS = 13;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vgaram_state_e;

  // Number of writes a full-screen fill issues for a given address width.
  function automatic int unsigned fill_length(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/vgaram_clear_seq.sv
// Fill address sequencer: walks 0..2^ADDR_BITS-1 one step per cycle and flags
// the last address; wraps naturally back to 0.
module vgaram_clear_seq #(
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 step_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_o
);

  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr_o = cnt_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/vgaram_arbiter.sv
// VGA RAM write arbiter: CPU and sprite writers share one registered write port,
// with a full-screen fill mode. Define VGARAM_CPU_PRIORITY_EN for fixed CPU priority.
module vgaram_arbiter
  import vgaram_pkg::*;
#(
  parameter int WIDTH         = VGARAM_WIDTH,
  parameter int RAM_ADDR_BITS = VGARAM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic [RAM_ADDR_BITS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]         cpu_wdata,
  output logic                     cpu_gnt,
  input  logic                     spr_req,
  input  logic [RAM_ADDR_BITS-1:0] spr_addr,
  input  logic [WIDTH-1:0]         spr_wdata,
  output logic                     spr_gnt,
  input  logic                     clr_start,
  input  logic [WIDTH-1:0]         clr_value,
  output logic                     clr_busy,
  output logic                     ram_en,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [WIDTH-1:0]         ram_wdata
);

  vgaram_state_e            state_q, state_d;
  logic [WIDTH-1:0]         clr_val_q, clr_val_d;
  logic                     ram_en_q, ram_en_d;
  logic [RAM_ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]         ram_wdata_q, ram_wdata_d;
  logic                     last_spr_q, last_spr_d;

  logic                     cpu_first;
  logic                     fill_start;
  logic                     fill_step;
  logic                     fill_last;
  logic [RAM_ADDR_BITS-1:0] fill_addr;

`ifdef VGARAM_CPU_PRIORITY_EN
  assign cpu_first = 1'b1;
`else
  // Round-robin: the CPU wins a collision only if the sprite engine went last.
  assign cpu_first = last_spr_q;
`endif

  always_comb begin
    state_d     = state_q;
    clr_val_d   = clr_val_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    last_spr_d  = last_spr_q;
    cpu_gnt     = 1'b0;
    spr_gnt     = 1'b0;
    fill_start  = 1'b0;
    fill_step   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d    = CLEAR;
          clr_val_d  = clr_value;
          fill_start = 1'b1;
        end else if (!reset) begin
          if (cpu_req && (!spr_req || cpu_first)) begin
            cpu_gnt     = 1'b1;
            ram_en_d    = 1'b1;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            last_spr_d  = 1'b0;
          end else if (spr_req) begin
            spr_gnt     = 1'b1;
            ram_en_d    = 1'b1;
            ram_addr_d  = spr_addr;
            ram_wdata_d = spr_wdata;
            last_spr_d  = 1'b1;
          end
        end
      end
      CLEAR: begin
        fill_step   = 1'b1;
        ram_en_d    = 1'b1;
        ram_addr_d  = fill_addr;
        ram_wdata_d = clr_val_q;
        if (fill_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_val_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      last_spr_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_val_q   <= clr_val_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      last_spr_q  <= last_spr_d;
    end
  end

  vgaram_clear_seq #(
    .ADDR_BITS(RAM_ADDR_BITS)
  ) u_clear_seq (
    .clk    (clk),
    .reset  (reset),
    .start_i(fill_start),
    .step_i (fill_step),
    .addr_o (fill_addr),
    .last_o (fill_last)
  );

  assign clr_busy  = (state_q == CLEAR);
  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vgaram_arbiter.sv
// Self-checking bench for vgaram_arbiter (default 16-bit data, 13-bit address).
module tb_vgaram_arbiter;

`ifdef VGARAM_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int FILL_N = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, spr_req, clr_start;
  logic [12:0] cpu_addr, spr_addr;
  logic [15:0] cpu_wdata, spr_wdata, clr_value;
  logic        cpu_gnt, spr_gnt, clr_busy, ram_en;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;

  int tests = 0;
  int fails = 0;

  vgaram_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(13)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_gnt  (cpu_gnt),
    .spr_req  (spr_req),
    .spr_addr (spr_addr),
    .spr_wdata(spr_wdata),
    .spr_gnt  (spr_gnt),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .clr_busy (clr_busy),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        cr;
    logic [12:0] ca;
    logic [15:0] cd;
    logic        sr;
    logic [12:0] sa;
    logic [15:0] sd;
    logic        gc;
    logic        gs;
    logic        ee;
    logic [12:0] ea;
    logic [15:0] ed;
  } vec_t;

  function automatic vec_t mk(string n, logic cr, logic [12:0] ca, logic [15:0] cd,
                              logic sr, logic [12:0] sa, logic [15:0] sd,
                              logic gc, logic gs, logic ee, logic [12:0] ea, logic [15:0] ed);
    vec_t v;
    v = '{n, cr, ca, cd, sr, sa, sd, gc, gs, ee, ea, ed};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    spr_req = 1'b0; spr_addr = '0; spr_wdata = '0;
    clr_start = 1'b0; clr_value = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Fill sequence; optionally with a CPU write pending and a clr_start re-pulse mid-fill.
  task automatic run_fill(input logic [15:0] val, input bit with_cpu, input int restart_at);
    int busy_cnt, wr_cnt, wr_bad, gnt_early, first_idle;
    logic idle_gnt;
    busy_cnt = 0; wr_cnt = 0; wr_bad = 0; gnt_early = 0; first_idle = -1; idle_gnt = 1'b0;
    clr_start = 1'b1;
    clr_value = val;
    if (with_cpu) begin
      cpu_req = 1'b1; cpu_addr = 13'h0ABC; cpu_wdata = 16'h7777;
    end
    #1;
    chk("clr_start_no_grant", 32'({cpu_gnt, spr_gnt}), 32'd0);
    tick();
    clr_start = 1'b0;
    clr_value = ~val;
    for (int k = 0; k < FILL_N + 100; k++) begin
      if (k > 0) tick();
      if (clr_busy) busy_cnt++;
      if (clr_busy && (cpu_gnt || spr_gnt)) gnt_early++;
      if (k >= 1) begin
        if (!ram_en || ram_addr != 13'(k - 1) || ram_wdata != val) wr_bad++;
        if (ram_en) wr_cnt++;
      end
      if (!clr_busy) begin
        first_idle = k;
        idle_gnt = cpu_gnt;
        break;
      end
      clr_start = (k == restart_at);
    end
    clr_start = 1'b0;
    chk("fill_first_idle_cycle", 32'(first_idle), 32'(FILL_N));
    chk("fill_busy_cycles", 32'(busy_cnt), 32'(FILL_N));
    chk("fill_write_count", 32'(wr_cnt), 32'(FILL_N));
    chk("fill_write_errors", 32'(wr_bad), 32'd0);
    chk("fill_grant_while_busy", 32'(gnt_early), 32'd0);
    chk("post_fill_cpu_gnt", 32'(idle_gnt), 32'(with_cpu));
    tick();
    cpu_req = 1'b0;
    if (with_cpu) chk("post_fill_cpu_write", 32'({ram_en, ram_addr, ram_wdata}), 32'({1'b1, 13'h0ABC, 16'h7777}));
    else          chk("post_fill_no_write", 32'(ram_en), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    bit          mcp, msp, mlast_spr, ec, es, me, found;
    logic [12:0] mca, msa, ma;
    logic [15:0] mcd, msd, md;
    int          extra;

    tbl.push_back(mk("idle_after_reset", 0, 13'h0, 16'h0, 0, 13'h0, 16'h0, 0, 0, 0, 13'h0, 16'h0));
    tbl.push_back(mk("cpu_0010", 1, 13'h0010, 16'hBEEF, 0, 13'h0, 16'h0, 1, 0, 1, 13'h0010, 16'hBEEF));
    tbl.push_back(mk("hold_1", 0, 13'h0, 16'h0, 0, 13'h0, 16'h0, 0, 0, 0, 13'h0010, 16'hBEEF));
    tbl.push_back(mk("spr_0020", 0, 13'h0, 16'h0, 1, 13'h0020, 16'h1234, 0, 1, 1, 13'h0020, 16'h1234));
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk("collide_a", 1, 13'h0100, 16'hA0A0, 1, 13'h0200, 16'h5050,
                       1, 0, 1, 13'h0100, 16'hA0A0));
      tbl.push_back(mk("collide_b", 1, 13'h0100, 16'hA0A0, 1, 13'h0200, 16'h5050,
                       PRIO, !PRIO, 1, PRIO ? 13'h0100 : 13'h0200, PRIO ? 16'hA0A0 : 16'h5050));
    end
    tbl.push_back(mk("spr_only", 0, 13'h0, 16'h0, 1, 13'h0300, 16'h0F0F, 0, 1, 1, 13'h0300, 16'h0F0F));
    tbl.push_back(mk("cpu_max_addr", 1, 13'h1FFF, 16'hFFFF, 0, 13'h0, 16'h0, 1, 0, 1, 13'h1FFF, 16'hFFFF));
    tbl.push_back(mk("spr_zero", 0, 13'h0, 16'h0, 1, 13'h0000, 16'h0000, 0, 1, 1, 13'h0000, 16'h0000));
    tbl.push_back(mk("collide_after_spr", 1, 13'h0555, 16'h5555, 1, 13'h0AAA, 16'hAAAA,
                     1, 0, 1, 13'h0555, 16'h5555));
    tbl.push_back(mk("hold_2", 0, 13'h0, 16'h0, 0, 13'h0, 16'h0, 0, 0, 0, 13'h0555, 16'h5555));

    do_reset();
    chk("reset_outputs", 32'({ram_en, ram_addr, ram_wdata, clr_busy, cpu_gnt, spr_gnt}), 32'd0);

    foreach (tbl[i]) begin
      cpu_req = tbl[i].cr; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      spr_req = tbl[i].sr; spr_addr = tbl[i].sa; spr_wdata = tbl[i].sd;
      #1;
      chk({tbl[i].name, "_gnt"}, 32'({cpu_gnt, spr_gnt}), 32'({tbl[i].gc, tbl[i].gs}));
      tick();
      chk({tbl[i].name, "_ram"}, 32'({ram_en, ram_addr, ram_wdata}),
          32'({tbl[i].ee, tbl[i].ea, tbl[i].ed}));
    end

    // Random traffic against a request-level model: requests stay pending until granted.
    do_reset();
    mcp = 0; msp = 0; mlast_spr = 1; me = 0; ma = '0; md = '0;
    mca = '0; msa = '0; mcd = '0; msd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!mcp && $urandom_range(0, 2) != 0) begin
        mcp = 1; mca = 13'($urandom); mcd = 16'($urandom);
      end
      if (!msp && $urandom_range(0, 2) != 0) begin
        msp = 1; msa = 13'($urandom); msd = 16'($urandom);
      end
      cpu_req = mcp; cpu_addr = mca; cpu_wdata = mcd;
      spr_req = msp; spr_addr = msa; spr_wdata = msd;
      #1;
      ec = mcp && (!msp || PRIO || mlast_spr);
      es = msp && !ec;
      chk("rand_gnt", 32'({cpu_gnt, spr_gnt}), 32'({ec, es}));
      if (ec) begin
        me = 1; ma = mca; md = mcd; mcp = 0; mlast_spr = 0;
      end else if (es) begin
        me = 1; ma = msa; md = msd; msp = 0; mlast_spr = 1;
      end else begin
        me = 0;
      end
      tick();
      chk("rand_ram", 32'({ram_en, ram_addr, ram_wdata}), 32'({me, ma, md}));
    end
    idle_inputs();
    tick();

    run_fill(16'h001F, 1'b1, -1);
    run_fill(16'hC3A5, 1'b0, 4000);

    // Reset in the middle of a fill.
    clr_start = 1'b1; clr_value = 16'h0ABC;
    tick();
    clr_start = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (ram_en && ram_addr == 13'h0100) begin
        found = 1;
        break;
      end
    end
    chk("abort_reached_0100", 32'(found), 32'd1);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_addr = 13'h0042; cpu_wdata = 16'h4242;
    spr_req = 1'b1;
    #1;
    chk("gnt_during_reset", 32'({cpu_gnt, spr_gnt}), 32'd0);
    tick();
    chk("abort_en_busy", 32'({ram_en, clr_busy, ram_addr, ram_wdata}), 32'd0);
    reset = 1'b0;
    cpu_req = 1'b0; spr_req = 1'b0;
    extra = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (ram_en || clr_busy) extra++;
    end
    chk("abort_no_more_writes", 32'(extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vgaram_arbiter.md
VGARAM_ARBITER -- requirements
Module: vgaram_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the VGA RAM data width.
REQ-002 The block SHALL have parameter RAM_ADDR_BITS, default 13, the VGA RAM address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports cpu_req / cpu_addr / cpu_wdata, input, 1 / RAM_ADDR_BITS / WIDTH, the processor write request, address and data.
REQ-006 The block SHALL have port cpu_gnt, output, 1, the processor request accepted this cycle.
REQ-007 The block SHALL have ports spr_req / spr_addr / spr_wdata / spr_gnt, with the same widths and meaning as cpu_*, for the sprite (duck) engine.
REQ-008 The block SHALL have ports clr_start, input, 1, and clr_value, input, WIDTH, which start a full-screen fill with clr_value.
REQ-009 The block SHALL have port clr_busy, output, 1, high while a fill is in progress.
REQ-010 The block SHALL have ports ram_en / ram_addr / ram_wdata, output, 1 / RAM_ADDR_BITS / WIDTH, driving the VGA RAM write enable, write address and write data.

Function
REQ-011 The FSM SHALL have two states, IDLE and CLEAR.
REQ-012 cpu_gnt and spr_gnt SHALL be combinational, never both high, and only asserted in IDLE with no clr_start.
REQ-013 A requester SHALL hold req, addr and wdata stable until it sees gnt high; on that edge the request is consumed.
REQ-014 On the edge where a gnt is high, the granted addr/wdata SHALL be registered into ram_addr/ram_wdata, with ram_en=1 for exactly the following cycle (1-cycle latency).
REQ-015 When no grant or fill write occurs, ram_en SHALL be 0 and ram_addr/ram_wdata SHALL hold their values.
REQ-016 Both requesters SHALL be able to be granted back-to-back, one write per cycle, with no idle cycle.
REQ-017 Arbitration when both requesters are active SHALL follow REQ-030/031.
REQ-018 IDLE with clr_start=1 SHALL go to CLEAR, latch clr_value, and assert no grant that cycle (fill beats simultaneous requests).
REQ-019 In CLEAR the block SHALL issue one write per cycle at addresses 0,1,...,2^RAM_ADDR_BITS-1 with the latched value, ram_en=1 each of those cycles.
REQ-020 After the write to the last address the block SHALL return to IDLE; the address counter SHALL wrap to 0 without overflow side effects.
REQ-021 clr_busy SHALL be 1 exactly while the state is CLEAR.
REQ-022 In CLEAR all grants SHALL be 0 and clr_start SHALL be ignored; pending requests wait.
REQ-023 A fill SHALL take exactly 2^RAM_ADDR_BITS cycles of ram_en (8192 at default).

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, fill counter 0, ram_en 0, ram_addr 0, ram_wdata 0, clr_busy 0, and the round-robin pointer to "last=spr".
REQ-025 While reset=1, cpu_gnt and spr_gnt SHALL be 0.
REQ-026 Reset during CLEAR SHALL abort the fill immediately; no further fill writes occur.

Configuration
REQ-030 With VGARAM_CPU_PRIORITY_EN defined, cpu_req SHALL always win over spr_req.
REQ-031 Without VGARAM_CPU_PRIORITY_EN, arbitration SHALL be round-robin: on a collision, grant the requester not granted most recently; the pointer updates only on a grant.

Structure
REQ-032 The shared package vgaram_pkg SHALL hold the WIDTH/RAM_ADDR_BITS defaults and the IDLE/CLEAR state encoding.
REQ-033 The fill address counter and its last-address detection SHALL be the sub-module vgaram_clear_seq.

Verification
REQ-034 Bench SHALL check: cpu_req with addr 0x0010 and data 0xBEEF -> cpu_gnt that cycle; next cycle ram_en=1, ram_addr=0x0010, ram_wdata=0xBEEF.
REQ-035 Bench SHALL check: cpu_req and spr_req held for 4 cycles -> without the macro, grants cpu,spr,cpu,spr; with the macro, cpu on all four.
REQ-036 Bench SHALL check: clr_start with clr_value 0x001F -> 8192 consecutive writes at addresses 0..0x1FFF, clr_busy high 8192 cycles, then IDLE.
REQ-037 Bench SHALL check: clr_start and cpu_req in the same cycle -> no grant; the cpu write is granted the first IDLE cycle after the fill.
REQ-038 Bench SHALL check: reset at fill address 0x0100 -> ram_en 0 next cycle, clr_busy 0, no further fill writes.
REQ-039 Bench SHALL check: clr_start pulsed again mid-fill -> ignored, and the fill still ends after exactly 8192 writes.
